// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scan-out (320x240 shown pixel-doubled
// on 640x480) and a req/ack writer. Display fetches always win; the writer gets every other cycle.
module vga_fb_arbiter #(
   parameter int H_START   = 1,
   parameter int V_START   = 1,
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 17
) (
   input  logic              clk_25MHz,
   input  logic              reset,
   input  logic [15:0]       h_count,
   input  logic [15:0]       v_count,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] pixel_data,
   output logic              pixel_valid,
   output logic              vblank_pulse
);
   localparam int FB_W = H_VISIBLE / 2;
   localparam int FB_H = V_VISIBLE / 2;

   localparam logic [15:0]       H_START_C   = 16'(H_START);
   localparam logic [15:0]       V_START_C   = 16'(V_START);
   localparam logic [15:0]       H_VIS_C     = 16'(H_VISIBLE);
   localparam logic [15:0]       V_VIS_C     = 16'(V_VISIBLE);
   localparam logic [15:0]       VBLANK_V_C  = 16'(V_START + V_VISIBLE);
   localparam logic [ADDR_W-1:0] FB_W_C      = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] FB_SIZE_C   = ADDR_W'(FB_W * FB_H);

   localparam logic [0:0] WAIT_FRAME = 1'b0;
   localparam logic [0:0] RUN        = 1'b1;

   logic [0:0]        state_r;
   logic [0:0]        state_next_s;
   logic [15:0]       hx_s;
   logic [15:0]       vy_s;
   logic              visible_s;
   logic              frame_start_s;
   logic              run_s;
   logic              fetch_s;
   logic              grant_s;
   logic [ADDR_W-1:0] fetch_addr_s;
   logic              vis_d1_r;
   logic              vis_d2_r;
   logic              fetch_d1_r;
   logic              fetch_d2_r;

   // Slot decode: the frame-start cycle already fetches, so pixel (0,0) is never skipped.
   always_comb begin
      hx_s          = h_count - H_START_C;
      vy_s          = v_count - V_START_C;
      visible_s     = (hx_s < H_VIS_C) && (vy_s < V_VIS_C);
      frame_start_s = (h_count == H_START_C) && (v_count == V_START_C);
      run_s         = (state_r == RUN) || frame_start_s;
      fetch_s       = run_s && visible_s && (hx_s[0] == 1'b0);
      fetch_addr_s  = ADDR_W'(vy_s[15:1]) * FB_W_C + ADDR_W'(hx_s[15:1]);
      grant_s       = wr_req && !fetch_s && !wr_ack;
   end

   // Next-state logic for the frame synchroniser.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         WAIT_FRAME: begin
            if (frame_start_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = WAIT_FRAME;
            end
         end
         RUN:     state_next_s = RUN;
         default: state_next_s = WAIT_FRAME;
      endcase
   end

   // State register.
   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         state_r <= WAIT_FRAME;
      end else begin
         state_r <= state_next_s;
      end
   end

   // RAM port: display fetch, writer grant, or idle with the address held.
   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         wr_ack    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= {ADDR_W{1'b0}};
         ram_wdata <= {DATA_W{1'b0}};
      end else if (fetch_s) begin
         wr_ack    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= fetch_addr_s;
      end else if (grant_s) begin
         wr_ack    <= 1'b1;
         ram_we    <= (wr_addr < FB_SIZE_C);
         ram_addr  <= wr_addr;
         ram_wdata <= wr_data;
      end else begin
         wr_ack    <= 1'b0;
         ram_we    <= 1'b0;
      end
   end

   // Scan-out pipeline: track the RAM read latency and show each fetched word for two columns.
   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         vis_d1_r     <= 1'b0;
         vis_d2_r     <= 1'b0;
         fetch_d1_r   <= 1'b0;
         fetch_d2_r   <= 1'b0;
         pixel_valid  <= 1'b0;
         pixel_data   <= {DATA_W{1'b0}};
         vblank_pulse <= 1'b0;
      end else begin
         vis_d1_r     <= run_s && visible_s;
         vis_d2_r     <= vis_d1_r;
         fetch_d1_r   <= fetch_s;
         fetch_d2_r   <= fetch_d1_r;
         pixel_valid  <= vis_d2_r;
         vblank_pulse <= (h_count == H_START_C) && (v_count == VBLANK_V_C);
         if (fetch_d2_r) begin
            pixel_data <= ram_rdata;
         end else if (vis_d2_r) begin
            pixel_data <= pixel_data;
         end else begin
            pixel_data <= {DATA_W{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: stimulus queues expected acks/pixels, a negedge monitor checks them.
module tb_vga_fb_arbiter;
   typedef struct packed {
      logic [16:0] addr;
      logic [7:0]  data;
      logic        we;
   } wr_t;

   logic        clk_25MHz = 1'b0;
   logic        reset;
   logic [15:0] h_count;
   logic [15:0] v_count;
   logic        wr_req;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic [16:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  pixel_data;
   logic        pixel_valid;
   logic        vblank_pulse;

   int   n_checks = 0;
   int   n_fail = 0;
   wr_t  wr_q[$];
   wr_t  ack_q[$];
   logic [7:0] pix_q[$];
   int   vb_pending = 0;
   int   line_acks = 0;
   bit   exp_run = 1'b0;

   vga_fb_arbiter dut (
      .clk_25MHz(clk_25MHz), .reset(reset), .h_count(h_count), .v_count(v_count),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .vblank_pulse(vblank_pulse)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   // Synchronous-read RAM whose contents are a fixed function of the address.
   function automatic logic [7:0] pat(input logic [16:0] a);
      return a[7:0] ^ 8'h20;
   endfunction

   always @(posedge clk_25MHz) ram_rdata <= pat(ram_addr);

   function automatic bit vis(input logic [15:0] h, input logic [15:0] v);
      int hx = int'(h) - 1;
      int vy = int'(v) - 1;
      return (hx >= 0) && (hx < 640) && (vy >= 0) && (vy < 480);
   endfunction

   function automatic logic [7:0] exp_pix(input logic [15:0] h, input logic [15:0] v);
      int a = ((int'(v) - 1) / 2) * 320 + (int'(h) - 1) / 2;
      return pat(17'(a));
   endfunction

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_wr(input logic [16:0] a, input logic [7:0] d, input logic we);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.we   = we;
      wr_q.push_back(w);
      ack_q.push_back(w);
   endtask

   task automatic cyc();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic step(input logic [15:0] h, input logic [15:0] v);
      h_count = h;
      v_count = v;
      if (reset) exp_run = 1'b0;
      else if (h == 16'd1 && v == 16'd1) exp_run = 1'b1;
      if (!reset && exp_run && vis(h, v)) pix_q.push_back(exp_pix(h, v));
      if (!reset && h == 16'd1 && v == 16'd481) vb_pending++;
      cyc();
   endtask

   task automatic wait_writes(input logic [15:0] v);
      int n = 0;
      while ((wr_q.size() > 0 || wr_req || ack_q.size() > 0) && n < 400) begin
         step(16'd700, v);
         n++;
      end
      check(n < 400, "write_drain_timeout", 32'(n), 32'd400);
   endtask

   // Writer: holds each request until acked, then presents the next one.
   initial begin
      wr_t w;
      wr_req  = 1'b0;
      wr_addr = 17'd0;
      wr_data = 8'd0;
      forever begin
         cyc();
         if (wr_req && wr_ack) wr_req = 1'b0;
         if (!wr_req && wr_q.size() > 0) begin
            w = wr_q.pop_front();
            wr_addr = w.addr;
            wr_data = w.data;
            wr_req  = 1'b1;
         end
      end
   end

   // Monitor: pops expected acks/pixels/vblanks whenever the DUT presents them.
   initial begin
      wr_t  e;
      bit   prev_ack = 1'b0;
      bit   prev_run = 1'b0;
      bit   prev_vis = 1'b0;
      int   prev_hx = 0;
      logic [7:0] ep;
      forever begin
         @(negedge clk_25MHz);
         if (wr_ack) begin
            if (ack_q.size() == 0) begin
               check(1'b0, "unexpected_ack", {15'd0, ram_addr}, 32'd0);
            end else begin
               e = ack_q.pop_front();
               check({ram_addr, ram_wdata, ram_we} == {e.addr, e.data, e.we}, "write_port",
                     {6'd0, ram_addr, ram_wdata, ram_we}, {6'd0, e.addr, e.data, e.we});
            end
            check(!prev_ack, "ack_spacing", {31'd0, prev_ack}, 32'd0);
            if (prev_run && prev_vis) begin
               line_acks++;
               check(prev_hx[0] == 1'b1, "ack_on_fetch_slot", 32'(prev_hx), 32'd1);
            end
         end else begin
            check(ram_we == 1'b0, "idle_we", {31'd0, ram_we}, 32'd0);
         end
         if (pixel_valid) begin
            if (pix_q.size() == 0) begin
               check(1'b0, "unexpected_pixel", {24'd0, pixel_data}, 32'd0);
            end else begin
               ep = pix_q.pop_front();
               check(pixel_data == ep, "pixel_data", {24'd0, pixel_data}, {24'd0, ep});
            end
         end else begin
            check(pixel_data == 8'd0, "blank_pixel_zero", {24'd0, pixel_data}, 32'd0);
         end
         if (vblank_pulse) begin
            check(vb_pending > 0, "unexpected_vblank", 32'd1, 32'd0);
            if (vb_pending > 0) vb_pending--;
         end
         prev_ack = wr_ack;
         prev_run = exp_run;
         prev_vis = vis(h_count, v_count);
         prev_hx  = int'(h_count) - 1;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete, actual running required done");
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b1;
      h_count = 16'd700;
      v_count = 16'd500;
      push_wr(17'd100, 8'h11, 1'b1);

      // Reset held with a pending request: nothing is acked or written.
      cyc();
      check({ram_addr, ram_wdata, wr_ack, ram_we, pixel_valid, vblank_pulse} == 29'd0, "reset_state",
            {3'd0, ram_addr, ram_wdata, wr_ack, ram_we, pixel_valid, vblank_pulse}, 32'd0);
      check(pixel_data == 8'd0, "reset_pixel", {24'd0, pixel_data}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check(!wr_ack && !ram_we, "ack_in_reset", {30'd0, wr_ack, ram_we}, 32'd0);
      end
      reset = 1'b0;
      cyc();
      check(wr_ack == 1'b1, "first_ack_after_reset", {31'd0, wr_ack}, 32'd1);

      // Blanking writes at the last valid address and one past it.
      push_wr(17'd76799, 8'h22, 1'b1);
      push_wr(17'd76800, 8'h33, 1'b0);
      wait_writes(16'd500);
      check(ram_addr == 17'd76800, "dropped_write_addr", {15'd0, ram_addr}, 32'd76800);

      // Frame start, then a directed fetch at hx=10, vy=5.
      step(16'd1, 16'd1);
      check(ram_addr == 17'd0 && !ram_we, "fetch_origin", {14'd0, ram_addr, ram_we}, 32'd0);
      step(16'd2, 16'd1);
      step(16'd11, 16'd6);
      check(ram_addr == 17'd645 && !ram_we, "fetch_645", {14'd0, ram_addr, ram_we}, {14'd0, 17'd645, 1'b0});
      step(16'd12, 16'd6);
      step(16'd700, 16'd6);
      check(pixel_valid && pixel_data == 8'hA5, "pixel_t3", {23'd0, pixel_valid, pixel_data}, 32'h1A5);
      step(16'd700, 16'd6);
      check(pixel_valid && pixel_data == 8'hA5, "pixel_t4", {23'd0, pixel_valid, pixel_data}, 32'h1A5);
      step(16'd700, 16'd6);
      check(!pixel_valid, "pixel_t5", {31'd0, pixel_valid}, 32'd0);

      // Full visible line with the writer always requesting.
      for (int i = 0; i < 330; i++) push_wr(17'(1000 + i), 8'(i) ^ 8'h3C, 1'b1);
      step(16'd700, 16'd21);
      line_acks = 0;
      for (int h = 1; h <= 640; h++) step(16'(h), 16'd21);
      step(16'd700, 16'd21);
      check(line_acks == 320, "acks_per_line", 32'(line_acks), 32'd320);
      wait_writes(16'd21);

      // Start of vertical blanking.
      step(16'd1, 16'd481);
      check(vblank_pulse == 1'b1, "vblank_rise", {31'd0, vblank_pulse}, 32'd1);
      step(16'd2, 16'd481);
      check(vblank_pulse == 1'b0, "vblank_one_cycle", {31'd0, vblank_pulse}, 32'd0);
      for (int v = 482; v < 486; v++) begin
         step(16'd1, 16'(v));
         step(16'd300, 16'(v));
      end

      // Mid-frame reset: no pixels until the next frame start, which fetches address 0.
      step(16'd1, 16'd1);
      for (int h = 1; h <= 4; h++) step(16'(h), 16'd41);
      for (int i = 0; i < 3; i++) step(16'd700, 16'd41);
      reset = 1'b1;
      step(16'd5, 16'd43);
      step(16'd6, 16'd43);
      check(!pixel_valid && !wr_ack, "mid_reset_outputs", {30'd0, pixel_valid, wr_ack}, 32'd0);
      reset = 1'b0;
      push_wr(17'd500, 8'h77, 1'b1);
      for (int h = 7; h <= 12; h++) step(16'(h), 16'd43);
      wait_writes(16'd43);
      check(ram_addr == 17'd500, "wait_frame_write", {15'd0, ram_addr}, 32'd500);
      step(16'd1, 16'd1);
      check(ram_addr == 17'd0 && !ram_we, "resume_at_origin", {14'd0, ram_addr, ram_we}, 32'd0);
      for (int h = 2; h <= 4; h++) step(16'(h), 16'd1);
      for (int i = 0; i < 4; i++) step(16'd700, 16'd1);

      check(pix_q.size() == 0, "pixels_outstanding", 32'(pix_q.size()), 32'd0);
      check(ack_q.size() == 0, "acks_outstanding", 32'(ack_q.size()), 32'd0);
      check(vb_pending == 0, "vblank_outstanding", 32'(vb_pending), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
